// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the SM83 bus responder.
//   tstate_e      : T-state encoding, T1=0 .. T4=3 (matches tphase output)
//   resp_state_e  : responder FSM states
//   wrlog_t       : write-log entry {address, data}
//   OPEN_BUS_DEF  : default value driven on din when nothing answers
//   in_window()   : full 16-bit window compare, no aliasing
package cpu_bus_pkg;

    typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} tstate_e;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} resp_state_e;

    typedef struct packed {
        logic [15:0] adr;
        logic [7:0]  data;
    } wrlog_t;

    localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;

    // 17-bit arithmetic so a window ending at 16'hFFFF does not wrap.
    function automatic logic in_window(input logic [15:0] adr,
                                       input logic [15:0] base,
                                       input int unsigned depth_log2);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, base};
        hi = lo + (17'd1 << depth_log2);
        return ({1'b0, adr} >= lo) && ({1'b0, adr} < hi);
    endfunction

endpackage

// File: rtl/cpu_bus_resp_ram.sv
// Single-port byte RAM: synchronous write, asynchronous read.
//   clk   : clock
//   we    : write enable, data stored on the rising edge
//   addr  : byte address (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
// Contents are not reset.
module cpu_bus_resp_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_bus_responder.sv
// T-cycle-accurate memory responder for the SM83/LR35902 external bus.
// A RAM window [BASE, BASE+2**DEPTH_LOG2-1] answers reads and writes;
// everything else reads as OPEN_BUS.
//   clk, nreset          : clock (one clk = one T-cycle), async active-low reset
//   cpu_adr/cpu_dout     : CPU address and write data
//   cpu_rd/cpu_wr/cpu_m1 : M-cycle strobes and opcode-fetch indicator
//   din                  : read data to CPU (OPEN_BUS when not driving)
//   tphase               : current T-state, 0=T1 .. 3=T4
//   wr_ack               : high during T4 of a committed in-window write
//   bus_err              : sticky, rd and wr latched together
// Optional (define CPU_BUS_RESP_WRLOG_EN): 4-entry show-ahead log of
// committed writes on log_pop / log_valid / log_data / log_ovf.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'hC000,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [7:0]  OPEN_BUS   = OPEN_BUS_DEF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_m1,
    output logic [7:0]  din,
    output logic [1:0]  tphase,
    output logic        wr_ack,
    output logic        bus_err
`ifdef CPU_BUS_RESP_WRLOG_EN
    ,
    input  logic        log_pop,
    output logic        log_valid,
    output logic [23:0] log_data,
    output logic        log_ovf
`endif
);

    // Reset asserts asynchronously and releases two clocks after nreset rises.
    logic [1:0] rst_sync;
    logic       rst_n_i;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    tstate_e     t_q, t_cur, t_nxt;
    resp_state_e st_q, st_d;
    logic        m1_q, m1_rise;
    logic [15:0] adr_q;
    logic [7:0]  wdat_q;
    logic        wr_ack_q, bus_err_q;
    logic        commit_d, err_set, win;
    logic [DEPTH_LOG2-1:0] ofs;
    logic [7:0]  ram_rdata;

    // A fresh cpu_m1 rise makes the current clk T1 regardless of the counter.
    assign m1_rise = cpu_m1 & ~m1_q;
    assign t_cur   = m1_rise ? T1 : t_q;
    assign t_nxt   = tstate_e'(t_cur + 2'd1);
    assign tphase  = t_cur;

    assign win = in_window(adr_q, BASE, DEPTH_LOG2);
    assign ofs = DEPTH_LOG2'(adr_q - BASE);

    // The FSM state is the latched strobe: READ covers rd and rd+wr,
    // WRITE is a clean write.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q  <= T1;
            st_q <= S_IDLE;
            m1_q <= 1'b0;
        end else begin
            t_q  <= t_nxt;
            st_q <= st_d;
            m1_q <= cpu_m1;
        end
    end

    always_comb begin
        st_d     = st_q;
        commit_d = 1'b0;
        err_set  = 1'b0;
        unique case (t_cur)
            T1: begin
                err_set = cpu_rd & cpu_wr;
                if (cpu_rd)      st_d = S_READ;
                else if (cpu_wr) st_d = S_WRITE;
                else             st_d = S_IDLE;
            end
            T3: commit_d = (st_q == S_WRITE) & cpu_wr & win;
            T4: st_d = S_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            adr_q     <= '0;
            wdat_q    <= '0;
            wr_ack_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (t_cur == T1) adr_q  <= cpu_adr;
            if (commit_d)    wdat_q <= cpu_dout;
            wr_ack_q <= commit_d;
            if (err_set) bus_err_q <= 1'b1;
        end
    end

    // wr_ack_q doubles as the RAM write enable: data lands on the T4 edge.
    cpu_bus_resp_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (wr_ack_q),
        .addr  (ofs),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    // Gated at T1 so a stale READ state never leaks into the next M-cycle.
    assign din     = (st_q == S_READ && t_cur != T1 && win) ? ram_rdata : OPEN_BUS;
    assign wr_ack  = wr_ack_q;
    assign bus_err = bus_err_q;

`ifdef CPU_BUS_RESP_WRLOG_EN
    wrlog_t     log_mem [4];
    logic [1:0] log_wp, log_rp;
    logic [2:0] log_cnt;
    logic       log_ovf_q, log_push, log_do_pop, log_accept;

    assign log_push   = wr_ack_q;
    assign log_do_pop = log_pop & (log_cnt != 3'd0);
    // A full FIFO still accepts when the head leaves in the same clk.
    assign log_accept = log_push & ((log_cnt != 3'd4) | log_do_pop);

    always_ff @(posedge clk) begin
        if (log_accept) log_mem[log_wp] <= '{adr: adr_q, data: wdat_q};
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            log_wp    <= '0;
            log_rp    <= '0;
            log_cnt   <= '0;
            log_ovf_q <= 1'b0;
        end else begin
            if (log_accept) log_wp <= log_wp + 2'd1;
            if (log_do_pop) log_rp <= log_rp + 2'd1;
            case ({log_accept, log_do_pop})
                2'b10:   log_cnt <= log_cnt + 3'd1;
                2'b01:   log_cnt <= log_cnt - 3'd1;
                default: ;
            endcase
            if (log_push && !log_accept) log_ovf_q <= 1'b1;
        end
    end

    assign log_valid = (log_cnt != 3'd0);
    assign log_data  = log_mem[log_rp];
    assign log_ovf   = log_ovf_q;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    localparam logic [15:0] BASE = 16'hC000;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_m1 = 1'b0;
    logic [7:0]  din;
    logic [1:0]  tphase;
    logic        wr_ack, bus_err;
`ifdef CPU_BUS_RESP_WRLOG_EN
    logic        log_pop = 1'b0;
    logic        log_valid, log_ovf;
    logic [23:0] log_data;
    logic [23:0] logq[$];
    bit          exp_ovf = 1'b0;
`endif

    int n_tests = 0, n_fail = 0;
    logic [7:0] mem [256];
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    cpu_bus_responder dut (
        .clk(clk), .nreset(nreset), .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_m1(cpu_m1),
        .din(din), .tphase(tphase), .wr_ack(wr_ack), .bus_err(bus_err)
`ifdef CPU_BUS_RESP_WRLOG_EN
        , .log_pop(log_pop), .log_valid(log_valid), .log_data(log_data), .log_ovf(log_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit inwin(input logic [15:0] a);
        return (a >= BASE) && (a <= BASE + 16'd255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_m1 = 0; cpu_rd = 0; cpu_wr = 0;
        repeat (n) tick();
    endtask

    // One full M-cycle; entered just after the edge that starts T1.
    task automatic mcyc(input bit m1, input bit rd, input bit wr,
                        input logic [15:0] adr, input logic [7:0] dat, input bit drop_wr);
        logic [7:0] off, ed;
        bit hit, commit;
        off    = 8'(adr - BASE);
        hit    = inwin(adr);
        ed     = (rd && hit) ? mem[off] : 8'hFF;
        commit = wr && !rd && hit && !drop_wr;
        if (rd && wr) exp_err = 1'b1;
        cpu_m1 = m1; cpu_rd = rd; cpu_wr = wr; cpu_adr = adr; cpu_dout = dat;
        @(negedge clk);
        chk("tph_t1", tphase, 0);
        chk("din_t1", din, 8'hFF);
        tick();
        cpu_m1 = 0;
        cpu_adr = 16'($urandom);
        if (drop_wr) cpu_wr = 0;
        @(negedge clk);
        chk("tph_t2", tphase, 1);
        chk("din_t2", din, ed);
        chk("bus_err", bus_err, exp_err);
        tick();
        @(negedge clk);
        chk("tph_t3", tphase, 2);
        chk("din_t3", din, ed);
        chk("wrack_t3", wr_ack, 0);
        tick();
        cpu_dout = 8'($urandom);
        @(negedge clk);
        chk("tph_t4", tphase, 3);
        chk("din_t4", din, ed);
        chk("wrack_t4", wr_ack, commit);
        tick();
        cpu_rd = 0; cpu_wr = 0;
        if (commit) begin
            mem[off] = dat;
`ifdef CPU_BUS_RESP_WRLOG_EN
            if (logq.size() < 4) logq.push_back({adr, dat});
            else exp_ovf = 1'b1;
`endif
        end
    endtask

    task automatic release_reset();
        cpu_m1 = 0; cpu_rd = 0; cpu_wr = 0;
        nreset = 1;
        repeat (2) tick();
        exp_err = 1'b0;
`ifdef CPU_BUS_RESP_WRLOG_EN
        logq.delete();
        exp_ovf = 1'b0;
`endif
    endtask

    initial begin
        logic [15:0] bnd [4];
        logic [15:0] a;
        bit rd, wr;
        bnd = '{16'hC000, 16'hC0FF, 16'hC100, 16'hBFFF};

        repeat (3) tick();
        @(negedge clk);
        chk("rst_tph", tphase, 0);
        chk("rst_din", din, 8'hFF);
        chk("rst_wrack", wr_ack, 0);
        chk("rst_err", bus_err, 0);
        tick();
        release_reset();

        // Fill the whole window so every later read has a known value.
        for (int i = 0; i < 256; i++)
            mcyc(i == 0, 0, 1, BASE + 16'(i), 8'($urandom), 0);

        mcyc(1, 0, 1, 16'hC010, 8'h5A, 0);
        mcyc(1, 1, 0, 16'hC010, 8'h00, 0);
        chk("mem_c010", mem[8'h10], 8'h5A);
        mcyc(0, 0, 1, 16'hC0FF, 8'hA5, 0);
        mcyc(0, 1, 0, 16'hC0FF, 8'h00, 0);
        mcyc(0, 1, 0, 16'hC100, 8'h00, 0);
        mcyc(0, 1, 0, 16'hBFFF, 8'h00, 0);
        mcyc(0, 0, 1, 16'hC100, 8'h3C, 0);
        mcyc(0, 1, 0, 16'hC000, 8'h00, 0);
        mcyc(0, 1, 1, 16'hC001, 8'h33, 0);
        mcyc(0, 1, 0, 16'hC001, 8'h00, 0);
        mcyc(0, 0, 1, 16'hC030, 8'h77, 1);
        mcyc(0, 1, 0, 16'hC030, 8'h00, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       a = bnd[$urandom_range(0, 3)];
                1:       a = 16'($urandom);
                default: a = BASE + 16'($urandom_range(0, 255));
            endcase
            rd = ($urandom_range(0, 1) == 1);
            wr = rd ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            mcyc($urandom_range(0, 1) == 1, rd, wr, a, 8'($urandom),
                 wr && !rd && ($urandom_range(0, 3) == 0));
        end

        // Misaligned resync: cpu_m1 rises while the counter is at T3.
        idle(2);
        mcyc(1, 1, 0, 16'hC010, 8'h00, 0);

        // Reset during T3 of a write drops it.
        cpu_rd = 0; cpu_wr = 1; cpu_adr = 16'hC020; cpu_dout = ~mem[8'h20];
        tick();
        tick();
        nreset = 0;
        #1;
        chk("rstmid_tph", tphase, 0);
        chk("rstmid_din", din, 8'hFF);
        chk("rstmid_wrack", wr_ack, 0);
        chk("rstmid_err", bus_err, 0);
        tick();
        tick();
        release_reset();
        mcyc(1, 1, 0, 16'hC020, 8'h00, 0);

`ifdef CPU_BUS_RESP_WRLOG_EN
        @(negedge clk);
        chk("log_empty", log_valid, 0);
        tick();
        for (int i = 0; i < 5; i++)
            mcyc(1, 0, 1, 16'hC040 + 16'(i), 8'($urandom), 0);
        @(negedge clk);
        chk("log_valid_full", log_valid, 1);
        chk("log_ovf", log_ovf, exp_ovf);
        chk("log_depth", logq.size(), 4);
        while (logq.size() > 0) begin
            @(negedge clk);
            chk("log_valid", log_valid, 1);
            chk("log_data", log_data, logq[0]);
            #1;
            @(posedge clk);
            #1;
            log_pop = 1;
            tick();
            log_pop = 0;
            void'(logq.pop_front());
        end
        @(negedge clk);
        chk("log_drained", log_valid, 0);
        chk("log_ovf_sticky", log_ovf, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
